id_ex_stage: RTL and testbench

Decode stage plus ID/EX pipeline register for the 5-stage RV32I pipeline. It drives the `RegisterFile` read addresses from the fetched instruction, decodes control fields, and generates the sign-extended immediate. It detects load-use hazards, applies stall/flush/bubble rules, and registers everything into the EX stage one cycle later. x0 reads are forced to zero here because the register file does not hardwire x0.

---
 rtl/id_ex_stage.sv | 108 ++++++++++
 tb/tb_id_ex_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode plus ID/EX pipeline register with load-use stall detection.
// Optional feature: define ID_WB_BYPASS_EN to forward the WB write data into ID operands.
module id_ex_stage (
  input  logic        clk,
  input  logic        rstn,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mem_stall,
  input  logic        ex_flush,
  output logic        id_stall,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [2:0]  ex_funct3,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        ex_illegal
);
  logic [6:0]   opc;
  logic [4:0]   rs1, rs2, rd;
  logic [2:0]   funct3;
  logic         is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, legal;
  logic         use1, use2;
  logic [31:0]  imm, a, b;
  logic [3:0]   f3op, alu_op;
  logic [10:0]  ctrl;
  logic [157:0] d, q;
  assign opc      = if_instr[6:0];
  assign rd       = if_instr[11:7];
  assign funct3   = if_instr[14:12];
  assign rs1      = if_instr[19:15];
  assign rs2      = if_instr[24:20];
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;
  assign is_r     = opc == 7'b0110011;
  assign is_i     = opc == 7'b0010011;
  assign is_ld    = opc == 7'b0000011;
  assign is_st    = opc == 7'b0100011;
  assign is_br    = opc == 7'b1100011;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign legal    = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;
  assign use1     = is_r | is_i | is_ld | is_st | is_br | is_jalr;
  assign use2     = is_r | is_st | is_br;
  assign imm = (is_i | is_ld | is_jalr) ? {{20{if_instr[31]}}, if_instr[31:20]} :
               is_st ? {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]} :
               is_br ? {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0} :
               (is_lui | is_auipc) ? {if_instr[31:12], 12'b0} :
               is_jal ? {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0} :
               32'd0;
`ifdef ID_WB_BYPASS_EN
  assign a = (rs1 == 5'd0) ? 32'd0 : (wb_we && wb_rd == rs1) ? wb_data : rf_rdata1;
  assign b = (rs2 == 5'd0) ? 32'd0 : (wb_we && wb_rd == rs2) ? wb_data : rf_rdata2;
`else
  assign a = (rs1 == 5'd0) ? 32'd0 : rf_rdata1;
  assign b = (rs2 == 5'd0) ? 32'd0 : rf_rdata2;
`endif
  // funct3 to base ALU operation; SUB/SRA are the +1 neighbours of ADD/SRL
  always_comb begin
    f3op = 4'd0;
    case (funct3)
      3'd1: f3op = 4'd2;
      3'd2: f3op = 4'd3;
      3'd3: f3op = 4'd4;
      3'd4: f3op = 4'd5;
      3'd5: f3op = 4'd6;
      3'd6: f3op = 4'd8;
      3'd7: f3op = 4'd9;
      default: f3op = 4'd0;
    endcase
  end
  assign alu_op = is_r ? f3op + {3'b0, if_instr[30] & (funct3 == 3'd0 | funct3 == 3'd5)} :
                  is_i ? f3op + {3'b0, if_instr[30] & (funct3 == 3'd5)} :
                  is_lui ? 4'd10 : 4'd0;
  assign ctrl = {alu_op, ~(is_r | is_br), is_ld, is_st,
                 (is_r | is_i | is_ld | is_jal | is_jalr | is_lui | is_auipc) & (rd != 5'd0),
                 is_br, is_jal | is_jalr, ~legal};
  assign id_stall = if_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                    ((use1 & (ex_rd == rs1)) | (use2 & (ex_rd == rs2)));
  assign d = {if_valid, if_pc, a, b, imm, rs1, rs2, rd, funct3, if_valid ? ctrl : 11'd0};
  // ID/EX register: reset, then hold on back-end stall, bubble on flush or load-use, else capture
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) q <= '0;
    else if (!mem_stall) q <= (ex_flush | id_stall) ? '0 : d;
  assign {ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3,
          ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump,
          ex_illegal} = q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed checks of id_ex_stage against a behavioural model.
module tb_id_ex_stage;
  logic        clk = 0, rstn = 1;
  logic        if_valid = 0, wb_we = 0, mem_stall = 0, ex_flush = 0;
  logic [31:0] if_pc = 0, if_instr = 0, rf_rdata1 = 0, rf_rdata2 = 0, wb_data = 0;
  logic [4:0]  wb_rd = 0, rf_raddr1, rf_raddr2, ex_rs1, ex_rs2, ex_rd;
  logic        id_stall, ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_branch, ex_jump, ex_illegal;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_alu_op;
`ifdef ID_WB_BYPASS_EN
  localparam bit BYP = 1;
`else
  localparam bit BYP = 0;
`endif
  typedef struct packed {
    logic v; logic [31:0] pc, a, b, imm; logic [4:0] rs1, rs2, rd; logic [2:0] f3;
    logic [3:0] op; logic src, mr, mw, rw, br, j, ill;
  } ex_t;
  ex_t m;
  logic [31:0] regs [32];
  logic [3:0]  f3map [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
  logic [6:0]  ops [13] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17,
                            7'h7F, 7'h00, 7'h0F, 7'h73};
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rstn(rstn), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .mem_stall(mem_stall), .ex_flush(ex_flush),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] opv(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return 0;
    if (BYP && wb_we && wb_rd == idx) return wb_data;
    return rf;
  endfunction

  function automatic void dec(output ex_t e, output bit u1, output bit u2);
    logic [31:0] x;
    logic [2:0]  f3;
    x = if_instr;
    f3 = x[14:12];
    e = '0; u1 = 0; u2 = 0;
    e.v = if_valid; e.pc = if_pc; e.rs1 = x[19:15]; e.rs2 = x[24:20]; e.rd = x[11:7]; e.f3 = f3;
    e.a = opv(e.rs1, rf_rdata1);
    e.b = opv(e.rs2, rf_rdata2);
    e.src = 1;
    case (x[6:0])
      7'h33: begin e.op = f3map[f3] + 4'(x[30] && (f3 == 0 || f3 == 5)); e.src = 0; e.rw = 1; u1 = 1; u2 = 1; end
      7'h13: begin e.op = f3map[f3] + 4'(x[30] && f3 == 5); e.imm = 32'($signed(x[31:20])); e.rw = 1; u1 = 1; end
      7'h03: begin e.imm = 32'($signed(x[31:20])); e.mr = 1; e.rw = 1; u1 = 1; end
      7'h23: begin e.imm = 32'($signed({x[31:25], x[11:7]})); e.mw = 1; u1 = 1; u2 = 1; end
      7'h63: begin e.imm = 32'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0})); e.br = 1; e.src = 0; u1 = 1; u2 = 1; end
      7'h6F: begin e.imm = 32'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0})); e.j = 1; e.rw = 1; end
      7'h67: begin e.imm = 32'($signed(x[31:20])); e.j = 1; e.rw = 1; u1 = 1; end
      7'h37: begin e.imm = {x[31:12], 12'b0}; e.op = 10; e.rw = 1; end
      7'h17: begin e.imm = {x[31:12], 12'b0}; e.rw = 1; end
      default: e.ill = 1;
    endcase
    if (e.rd == 0) e.rw = 0;
    if (!if_valid) begin
      e.op = 0; e.src = 0; e.mr = 0; e.mw = 0; e.rw = 0; e.br = 0; e.j = 0; e.ill = 0;
    end
  endfunction

  task automatic cmp();
    chk("ex_valid", 32'(ex_valid), 32'(m.v));
    chk("ex_pc", ex_pc, m.pc);
    chk("ex_rs1_val", ex_rs1_val, m.a);
    chk("ex_rs2_val", ex_rs2_val, m.b);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_regs", {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, m.rs1, m.rs2, m.rd});
    chk("ex_funct3", 32'(ex_funct3), 32'(m.f3));
    chk("ex_alu_op", 32'(ex_alu_op), 32'(m.op));
    chk("ex_ctrl", {25'd0, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_illegal},
        {25'd0, m.src, m.mr, m.mw, m.rw, m.br, m.j, m.ill});
  endtask

  task automatic drive(input logic [31:0] instr, input logic v, input logic fl, input logic st,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    if_instr = instr; if_valid = v; ex_flush = fl; mem_stall = st;
    wb_we = we; wb_rd = wrd; wb_data = wd; if_pc = $urandom & 32'hFFFF_FFFC;
    rf_rdata1 = regs[instr[19:15]];
    rf_rdata2 = regs[instr[24:20]];
  endtask

  task automatic cyc();
    ex_t d, nx;
    bit u1, u2, st;
    #1;
    dec(d, u1, u2);
    st = if_valid && m.v && m.mr && m.rd != 0 && ((u1 && m.rd == d.rs1) || (u2 && m.rd == d.rs2));
    chk("id_stall", 32'(id_stall), 32'(st));
    chk("rf_raddr", {22'd0, rf_raddr1, rf_raddr2}, {22'd0, if_instr[19:15], if_instr[24:20]});
    nx = mem_stall ? m : (ex_flush || st) ? '0 : d;
    @(posedge clk);
    #1;
    m = nx;
    cmp();
  endtask

  task automatic rnd();
    logic [31:0] x;
    x = $urandom;
    x[6:0] = ops[$urandom_range(0, 12)];
    x[11:7] = 5'($urandom_range(0, 7));
    x[19:15] = 5'($urandom_range(0, 7));
    x[24:20] = 5'($urandom_range(0, 7));
    drive(x, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hDEAD_BEEF;
    regs[5] = 5;
    regs[6] = 4;
    m = '0;
    #2 rstn = 0;
    #1 cmp();
    @(posedge clk); @(posedge clk);
    #1 rstn = 1;
    drive(32'h006281B3, 1, 0, 0, 0, 0, 0); cyc();
    chk("add_rs1", ex_rs1_val, 5);
    chk("add_rs2", ex_rs2_val, 4);
    chk("add_ctl", {ex_valid, ex_rd, ex_alu_op, ex_alu_src, ex_reg_write}, {1'b1, 5'd3, 4'd0, 1'b0, 1'b1});
    drive(32'hFE000CE3, 1, 0, 0, 0, 0, 0); cyc();
    chk("beq_imm", ex_imm, 32'hFFFF_FFF8);
    chk("beq_ctl", {ex_branch, ex_reg_write, ex_rs1_val, ex_rs2_val}, {1'b1, 1'b0, 64'd0});
    drive(32'h0000A383, 1, 0, 0, 0, 0, 0); cyc();
    drive(32'h00938433, 1, 0, 0, 0, 0, 0);
    #1 chk("lu_stall", 32'(id_stall), 1);
    cyc();
    chk("lu_bubble", 32'(ex_valid), 0);
    cyc();
    chk("lu_add", {ex_valid, ex_rs1, ex_rs2, ex_rd}, {1'b1, 5'd7, 5'd9, 5'd8});
    drive(32'h006281B3, 1, 0, 0, 1, 5, 32'h1234); cyc();
    chk("bypass", ex_rs1_val, BYP ? 32'h1234 : 32'd5);
    drive(32'h006281B3, 1, 0, 0, 0, 0, 0); cyc();
    for (int i = 0; i < 3; i++) begin
      drive(32'hFE000CE3, 1, i[0], 1, 0, 0, 0); cyc();
      chk("hold_rd", 32'(ex_rd), 3);
    end
    drive(32'hFE000CE3, 1, 1, 0, 0, 0, 0); cyc();
    chk("flush", 32'(ex_valid), 0);
    drive(32'h0000007F, 1, 0, 0, 0, 0, 0); cyc();
    chk("illegal", {ex_illegal, ex_reg_write}, {1'b1, 1'b0});
    drive(32'h00628033, 1, 0, 0, 0, 0, 0); cyc();
    chk("rd0", {ex_valid, ex_reg_write}, {1'b1, 1'b0});
    for (int i = 0; i < 2000; i++) begin rnd(); cyc(); end
    drive(32'h006281B3, 1, 0, 1, 0, 0, 0);
    #2 rstn = 0;
    #1 m = '0;
    cmp();
    @(posedge clk);
    #1 rstn = 1;
    for (int i = 0; i < 300; i++) begin rnd(); cyc(); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
